hall_input_conditioner: RTL and testbench
=========================================

// Module: hall_input_conditioner
// PURPOSE
//  Front end for the 3-bit Hall sensor inputs of each motor. Synchronises the raw pins,
//  rejects glitches shorter than FILT_LEN clocks, validates the 6-step Hall code and
//  decodes sector and direction. Emits one-cycle EDGE_P pulses per legal commutation
//  step; these feed the downstream Hall speed encoder in place of raw pin edges.
// PARAMETERS
//  SYNC_STAGES  2  flip-flops in input synchroniser chain (>=2)
//  FILT_LEN     4  consecutive clocks a new synced code must hold before acceptance (>=1)
// PORTS
//  CLK          in   1  system clock
//  RST          in   1  asynchronous, active-low reset
//  EN           in   1  1 = conditioning active; 0 = freeze outputs, flush filter
//  H_RAW        in   3  raw Hall pins {Hc,Hb,Ha}, asynchronous to CLK
//  CLR_ERR      in   1  synchronous clear of ERR_CNT
//  H_CLEAN      out  3  last accepted valid Hall code
//  SECTOR       out  3  1..6 decoded from H_CLEAN; 0 when no valid code held
//  EDGE_P       out  1  one-cycle pulse per accepted adjacent step
//  DIR          out  1  1 = forward, 0 = reverse (last adjacent step)
//  DIR_VALID    out  1  1 once an adjacent step is seen since INIT or last skip
//  ERR_INVALID  out  1  one-cycle pulse: accepted code is 000 or 111
//  ERR_SKIP     out  1  one-cycle pulse: valid code non-adjacent to H_CLEAN
//  ERR_CNT      out  8  saturating count of ERR_INVALID + ERR_SKIP events
// BEHAVIOUR
//  - Reset: sync chain, filter, all outputs = 0; state = INIT.
//  - Forward sequence (sector 1..6): 001,011,010,110,100,101, wrapping 101->001.
//    Reverse is the opposite order. 000/111 are invalid.
//  - Filter: cand = synced code. cnt resets to 0 when cand == H_CLEAN or cand differs
//    from the previous cycle's cand. Otherwise cnt increments. Accept when cnt == FILT_LEN-1.
//    The accept cycle also clears cnt.
//  - Latency: H_RAW stable from clock edge k -> outputs update at edge
//    k+SYNC_STAGES+FILT_LEN (7 with defaults). All outputs are registered.
//  - FSM states INIT, RUN.
//    INIT:
//      - Accepted valid code: load H_CLEAN/SECTOR, no EDGE_P, DIR_VALID=0 -> RUN.
//      - Accepted invalid code: ERR_INVALID pulse, stay INIT.
//    RUN, accepted code:
//      - Forward-adjacent: H_CLEAN updates, EDGE_P=1, DIR=1, DIR_VALID=1.
//      - Reverse-adjacent: H_CLEAN updates, EDGE_P=1, DIR=0, DIR_VALID=1.
//      - Distance 2 or 3: H_CLEAN updates, ERR_SKIP=1, no EDGE_P, DIR_VALID=0, DIR holds.
//      - Invalid: ERR_INVALID=1, H_CLEAN/SECTOR/DIR hold, stay RUN.
//    An invalid code is accepted once per stable episode; it re-fires only after the
//    synced value changes.
//  - Wrap 101<->001 is adjacent in both directions.
//  - EN=0: filter cnt cleared, pulses forced 0, H_CLEAN/SECTOR/DIR/ERR_CNT hold,
//    state -> INIT. Sync chain keeps running.
//    After EN returns to 1, the first accepted code re-seeds with no EDGE_P.
//  - ERR_CNT: +1 per error pulse, saturates at 255. CLR_ERR has priority:
//    a same-cycle error is not counted.
//  - RST assertion mid-filter or mid-pulse: immediate return to reset values.
// TESTING
//  1 Reset, H_RAW=001 held -> at edge 7: H_CLEAN=001, SECTOR=1, EDGE_P=0, DIR_VALID=0.
//  2 Step 001->011->010 each held 20 clk -> two EDGE_P pulses, DIR=1, DIR_VALID=1,
//    SECTOR=3. Reverse 010->011 -> EDGE_P, DIR=0.
//  3 From 011, 3-clk glitch to 010 then back -> no EDGE_P, H_CLEAN stays 011,
//    ERR_CNT unchanged. A 4-clk hold does step.
//  4 From 001, apply 110 for 10 clk -> ERR_SKIP pulse, DIR_VALID=0, SECTOR=4.
//    Apply 111 for 10 clk -> single ERR_INVALID, H_CLEAN=110, ERR_CNT=2.
//  5 Continuous forward rotation across 101->001 -> EDGE_P each step, DIR=1, no errors.
//    Deassert EN mid-rotation, reassert -> first code re-seeds, no EDGE_P.
//  6 Force 300 alternating 000/001 episodes -> ERR_CNT=255 saturates.
//    CLR_ERR coincident with ERR_INVALID -> ERR_CNT=0.

Source files
------------

// File: rtl/hall_input_conditioner.sv
// Hall sensor front end: synchronises the raw 3-bit Hall pins, filters out
// short glitches, validates the 6-step code and decodes sector/direction.
// One-cycle o_edge_p pulses mark each legal commutation step.
module hall_input_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   input  logic [2:0] i_h_raw,
   input  logic       i_clr_err,
   output logic [2:0] o_h_clean,
   output logic [2:0] o_sector,
   output logic       o_edge_p,
   output logic       o_dir,
   output logic       o_dir_valid,
   output logic       o_err_invalid,
   output logic       o_err_skip,
   output logic [7:0] o_err_cnt
);

   localparam int            CW     = $clog2(FILT_LEN + 1);
   localparam logic [CW-1:0] ACC_AT = CW'(FILT_LEN - 1);

   typedef enum logic {INIT, RUN} state_t;

   // Map a Hall code onto its position in the forward sequence (0 = invalid).
   function automatic logic [2:0] sec_of(input logic [2:0] code);
      logic [2:0] s;
      case (code)
         3'b001:  s = 3'd1;
         3'b011:  s = 3'd2;
         3'b010:  s = 3'd3;
         3'b110:  s = 3'd4;
         3'b100:  s = 3'd5;
         3'b101:  s = 3'd6;
         default: s = 3'd0;
      endcase
      return s;
   endfunction

   logic [SYNC_STAGES-1:0][2:0] r_sync;
   logic [2:0]                  r_prev;
   logic [CW-1:0]               r_cnt;
   logic                        r_inv_hold;
   logic                        r_acc;
   logic [2:0]                  r_acc_code;
   state_t                      r_state;
   logic [2:0]                  r_h_clean;
   logic [2:0]                  r_sector;
   logic                        r_edge_p;
   logic                        r_dir;
   logic                        r_dir_valid;
   logic                        r_err_invalid;
   logic                        r_err_skip;
   logic [7:0]                  r_err_cnt;

   logic [2:0]    w_cand;
   logic          w_chg;
   logic          w_blk;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_acc;
   logic [2:0]    w_new_sec;
   logic          w_valid;
   logic [2:0]    w_sec_fwd;
   logic [2:0]    w_sec_rev;
   logic          w_fwd;
   logic          w_rev;
   logic          w_take;
   logic          w_err_inv;
   logic          w_err_skip;

   // Input synchroniser chain; keeps running even while conditioning is disabled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_prev <= 3'd0;
      end else begin
         r_sync[0] <= i_h_raw;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   // Filter decision. The first cycle a new candidate is seen counts as clock 1,
   // so a code held FILT_LEN clocks is accepted on its last clock. An accepted
   // invalid code is latched out until the synced value changes again.
   always_comb begin
      w_cand    = r_sync[SYNC_STAGES-1];
      w_chg     = (w_cand != r_prev);
      w_blk     = (w_cand == r_h_clean) || (r_inv_hold && !w_chg);
      w_cnt_nxt = (w_chg || w_blk) ? '0 : r_cnt + CW'(1);
      w_acc     = !w_blk && (w_cnt_nxt == ACC_AT);
   end

   // Filter counter and acceptance register (one stage before the FSM).
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_inv_hold <= 1'b0;
         r_acc      <= 1'b0;
         r_acc_code <= 3'd0;
      end else begin
         if (w_chg) r_inv_hold <= 1'b0;
         if (!i_en) begin
            r_cnt <= '0;
            r_acc <= 1'b0;
         end else begin
            r_cnt      <= w_acc ? '0 : w_cnt_nxt;
            r_acc      <= w_acc;
            r_acc_code <= w_cand;
            if (w_acc && sec_of(w_cand) == 3'd0) r_inv_hold <= 1'b1;
         end
      end
   end

   // Classify the accepted code against the currently held one. A repeat of the
   // held code (possible with very short filters) is ignored.
   always_comb begin
      w_new_sec  = sec_of(r_acc_code);
      w_valid    = (w_new_sec != 3'd0);
      w_sec_fwd  = (r_sector == 3'd6) ? 3'd1 : r_sector + 3'd1;
      w_sec_rev  = (r_sector == 3'd1) ? 3'd6 : r_sector - 3'd1;
      w_fwd      = (w_new_sec == w_sec_fwd);
      w_rev      = (w_new_sec == w_sec_rev);
      w_take     = r_acc && i_en && (r_acc_code != r_h_clean);
      w_err_inv  = w_take && !w_valid;
      w_err_skip = w_take && w_valid && (r_state == RUN) && !w_fwd && !w_rev;
   end

   // INIT/RUN state machine with registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= INIT;
         r_h_clean     <= 3'd0;
         r_sector      <= 3'd0;
         r_edge_p      <= 1'b0;
         r_dir         <= 1'b0;
         r_dir_valid   <= 1'b0;
         r_err_invalid <= 1'b0;
         r_err_skip    <= 1'b0;
      end else if (!i_en) begin
         r_state       <= INIT;
         r_edge_p      <= 1'b0;
         r_err_invalid <= 1'b0;
         r_err_skip    <= 1'b0;
      end else begin
         r_edge_p      <= 1'b0;
         r_err_invalid <= w_err_inv;
         r_err_skip    <= w_err_skip;
         if (w_take && w_valid) begin
            r_h_clean <= r_acc_code;
            r_sector  <= w_new_sec;
            case (r_state)
               INIT: begin
                  r_dir_valid <= 1'b0;
                  r_state     <= RUN;
               end
               RUN: begin
                  if (w_fwd) begin
                     r_edge_p    <= 1'b1;
                     r_dir       <= 1'b1;
                     r_dir_valid <= 1'b1;
                  end else if (w_rev) begin
                     r_edge_p    <= 1'b1;
                     r_dir       <= 1'b0;
                     r_dir_valid <= 1'b1;
                  end else begin
                     r_dir_valid <= 1'b0;
                  end
               end
               default: r_state <= INIT;
            endcase
         end
      end
   end

   // Saturating error counter; a clear wins over an error in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err_cnt <= 8'd0;
      end else if (i_clr_err) begin
         r_err_cnt <= 8'd0;
      end else if ((w_err_inv || w_err_skip) && r_err_cnt != 8'hFF) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign o_h_clean     = r_h_clean;
   assign o_sector      = r_sector;
   assign o_edge_p      = r_edge_p;
   assign o_dir         = r_dir;
   assign o_dir_valid   = r_dir_valid;
   assign o_err_invalid = r_err_invalid;
   assign o_err_skip    = r_err_skip;
   assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_hall_input_conditioner.sv
// Directed bench for hall_input_conditioner with hand-computed expectations.
module tb_hall_input_conditioner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [2:0] h_raw;
   logic       clr_err;
   logic [2:0] h_clean;
   logic [2:0] sector;
   logic       edge_p;
   logic       dir;
   logic       dir_valid;
   logic       err_invalid;
   logic       err_skip;
   logic [7:0] err_cnt;

   int checks   = 0;
   int failures = 0;
   int n_edge   = 0;
   int n_inv    = 0;
   int n_skip   = 0;
   int e0, i0, s0;

   always #5 clk = ~clk;

   hall_input_conditioner dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_h_raw(h_raw), .i_clr_err(clr_err),
      .o_h_clean(h_clean), .o_sector(sector), .o_edge_p(edge_p), .o_dir(dir),
      .o_dir_valid(dir_valid), .o_err_invalid(err_invalid), .o_err_skip(err_skip),
      .o_err_cnt(err_cnt)
   );

   // Pulse counters sampled away from the active edge.
   always @(negedge clk) begin
      if (rst_n && edge_p)      n_edge++;
      if (rst_n && err_invalid) n_inv++;
      if (rst_n && err_skip)    n_skip++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [2:0] c, input int n);
      h_raw = c;
      tick(n);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; h_raw = 3'b001; clr_err = 1'b0;
      tick(3);
      // Reset state
      chk("rst_h_clean", h_clean, 0);
      chk("rst_sector", sector, 0);
      chk("rst_dir", dir, 0);
      chk("rst_err_cnt", err_cnt, 0);

      // 1: first accepted code lands exactly 7 edges after release
      rst_n = 1'b1;
      tick(6);
      chk("t1_not_yet", h_clean, 0);
      tick(1);
      chk("t1_h_clean", h_clean, 1);
      chk("t1_sector", sector, 1);
      chk("t1_edge_p", edge_p, 0);
      chk("t1_dir_valid", dir_valid, 0);

      // 2: forward steps then one reverse step
      e0 = n_edge;
      hold(3'b011, 20);
      hold(3'b010, 20);
      chk("t2_edges", n_edge - e0, 2);
      chk("t2_dir", dir, 1);
      chk("t2_dir_valid", dir_valid, 1);
      chk("t2_sector", sector, 3);
      hold(3'b011, 20);
      chk("t2_rev_edges", n_edge - e0, 3);
      chk("t2_rev_dir", dir, 0);
      chk("t2_rev_sector", sector, 2);

      // 3: 3-clk glitch rejected, 4-clk hold accepted
      e0 = n_edge;
      hold(3'b010, 3);
      hold(3'b011, 20);
      chk("t3_glitch_edges", n_edge - e0, 0);
      chk("t3_glitch_clean", h_clean, 3);
      chk("t3_glitch_err", err_cnt, 0);
      hold(3'b010, 4);
      h_raw = 3'b011;
      tick(3);
      chk("t3_hold4_pulse", edge_p, 1);
      chk("t3_hold4_clean", h_clean, 2);
      tick(17);
      chk("t3_back_clean", h_clean, 3);
      chk("t3_back_edges", n_edge - e0, 2);

      // 4: skip 001->110, then invalid 111 fires once
      hold(3'b001, 20);
      chk("t4_at_001", sector, 1);
      s0 = n_skip; i0 = n_inv;
      hold(3'b110, 10);
      chk("t4_skip_cnt", n_skip - s0, 1);
      chk("t4_skip_dv", dir_valid, 0);
      chk("t4_skip_sector", sector, 4);
      hold(3'b111, 10);
      chk("t4_inv_cnt", n_inv - i0, 1);
      chk("t4_inv_clean", h_clean, 6);
      chk("t4_err_cnt", err_cnt, 2);

      // 5: forward rotation across the 101->001 wrap
      e0 = n_edge; s0 = n_skip; i0 = n_inv;
      hold(3'b100, 10);
      hold(3'b101, 10);
      hold(3'b001, 10);
      hold(3'b011, 10);
      hold(3'b010, 10);
      hold(3'b110, 10);
      hold(3'b100, 10);
      chk("t5_edges", n_edge - e0, 7);
      chk("t5_dir", dir, 1);
      chk("t5_dir_valid", dir_valid, 1);
      chk("t5_errs", (n_skip - s0) + (n_inv - i0), 0);
      chk("t5_err_cnt", err_cnt, 2);
      // EN low freezes; re-enable re-seeds without a step pulse
      e0 = n_edge;
      en = 1'b0;
      hold(3'b101, 10);
      chk("t5_frozen_clean", h_clean, 4);
      en = 1'b1;
      tick(10);
      chk("t5_reseed_clean", h_clean, 5);
      chk("t5_reseed_sector", sector, 6);
      chk("t5_reseed_edges", n_edge - e0, 0);
      chk("t5_reseed_dv", dir_valid, 0);
      hold(3'b001, 10);
      chk("t5_wrap_edges", n_edge - e0, 1);
      chk("t5_wrap_dir", dir, 1);

      // 6: saturation, then clear coincident with an invalid pulse
      clr_err = 1'b1; tick(1); clr_err = 1'b0;
      chk("t6_cleared", err_cnt, 0);
      i0 = n_inv;
      for (int ep = 0; ep < 300; ep++) begin
         hold(3'b000, 5);
         hold(3'b001, 2);
      end
      tick(10);
      chk("t6_inv_events", n_inv - i0, 300);
      chk("t6_saturated", err_cnt, 255);
      chk("t6_clean_held", h_clean, 1);
      i0 = n_inv;
      h_raw = 3'b000;
      tick(6);
      clr_err = 1'b1;
      tick(1);
      chk("t6_coinc_pulse", err_invalid, 1);
      chk("t6_coinc_cnt", err_cnt, 0);
      clr_err = 1'b0;
      tick(10);
      chk("t6_after_cnt", err_cnt, 0);
      chk("t6_after_inv", n_inv - i0, 1);

      // Reset asserted mid-filter returns everything to zero at once
      hold(3'b011, 3);
      rst_n = 1'b0;
      #1;
      chk("rst2_h_clean", h_clean, 0);
      chk("rst2_sector", sector, 0);
      chk("rst2_err_cnt", err_cnt, 0);
      chk("rst2_dir", dir, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
